// File: rtl/ecc_pkg.sv
// SECDED helpers shared by the lockstep checker and its decoders.
// Hamming positions skip powers of two; the top check bit is overall parity.
package ecc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        CHECK = 2'd2
    } inj_state_t;

    // Check bits for dw data bits: smallest Hamming r with 2^r >= dw+r+1, plus overall parity.
    function automatic int ecc_par_w(input int dw);
        int r;
        r = 1;
        while ((1 << r) < (dw + r + 1)) r++;
        return r + 1;
    endfunction

    // H-matrix column of data bit idx: its 1-based codeword position (non-power-of-two slots).
    function automatic int ecc_h_col(input int idx);
        int p;
        int n;
        p = 2;
        n = -1;
        while (n < idx) begin
            p++;
            if ((p & (p - 1)) != 0) n++;
        end
        return p;
    endfunction

endpackage

// File: rtl/ecc_secded_dec.sv
// Combinational SECDED decoder: corrects one data bit, flags double errors.
// bypass_i passes data untouched and reports a clean beat.
module ecc_secded_dec
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH   = 70,
    parameter int PARITY_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic [PARITY_WIDTH-1:0] parity_i,
    input  logic                    bypass_i,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic [DATA_WIDTH-1:0]   mask_o,
    output logic                    sbit_err_o,
    output logic                    dbit_err_o
);

    localparam int SW = PARITY_WIDTH - 1;

    logic [SW-1:0]         contrib [DATA_WIDTH];
    logic [SW-1:0]         syn;
    logic [DATA_WIDTH-1:0] hit;
    logic                  overall;

    for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_col
        localparam logic [SW-1:0] COL = SW'(ecc_h_col(g));
        assign contrib[g] = COL & {SW{data_i[g]}};
        assign hit[g]     = (syn == COL);
    end

    always_comb begin
        syn = parity_i[SW-1:0];
        for (int i = 0; i < DATA_WIDTH; i++) begin
            syn = syn ^ contrib[i];
        end
    end

    assign overall = (^data_i) ^ (^parity_i);

    // Odd overall parity means a single flip; a zero or power-of-two syndrome hits a check bit.
    always_comb begin
        data_o     = data_i;
        mask_o     = '0;
        sbit_err_o = 1'b0;
        dbit_err_o = 1'b0;
        if (!bypass_i) begin
            mask_o     = overall ? hit : '0;
            data_o     = data_i ^ mask_o;
            sbit_err_o = overall;
            dbit_err_o = !overall && (syn != '0);
        end
    end

endmodule

// File: rtl/ecc_lockstep_chk.sv
// Lockstep dual-SECDED read-path checker with statistics and self-test; 1-cycle latency.
// No backpressure: every in_valid_i beat is accepted and reported on the next cycle.
module ecc_lockstep_chk
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH   = 70,
    parameter int PARITY_WIDTH = 8,
    parameter int CNT_WIDTH    = 16,
    parameter int FAULT_THRESH = 1,
    parameter int INJ_BIT      = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    input  logic [DATA_WIDTH-1:0]   data_in_i,
    input  logic [PARITY_WIDTH-1:0] parity_in_i,
    input  logic                    bypass_i,
    input  logic                    det_en_i,
    input  logic                    inj_req_i,
    input  logic                    cnt_clr_i,
    output logic                    out_valid_o,
    output logic [DATA_WIDTH-1:0]   data_out_o,
    output logic                    sbit_err_o,
    output logic                    dbit_err_o,
    output logic                    ecc_fault_o,
    output logic                    inj_busy_o,
    output logic                    inj_done_o,
    output logic                    inj_pass_o,
    output logic [CNT_WIDTH-1:0]    sbit_cnt_o,
    output logic [CNT_WIDTH-1:0]    dbit_cnt_o,
    output logic [CNT_WIDTH-1:0]    fault_cnt_o,
    output logic                    fault_sticky_o,
    output logic                    fault_irq_o
);

    localparam logic [DATA_WIDTH-1:0] INJ_MASK = DATA_WIDTH'(1) << INJ_BIT;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic [DATA_WIDTH-1:0] data0, mask0, data1, mask1, dec1_in;
    logic                  sbit0, dbit0, sbit1, dbit1;
    logic                  inj_beat, mismatch, fault_now;
    logic                  unused_data1;

    inj_state_t            inj_state_q;
    logic                  inj_busy_q, inj_done_q, inj_pass_q, inj_mis_q;

    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  sbit_q, sbit_d, dbit_q, dbit_d, fault_q, fault_d;
    logic [CNT_WIDTH-1:0]  sbit_cnt_q, sbit_cnt_d, dbit_cnt_q, dbit_cnt_d;
    logic [CNT_WIDTH-1:0]  fault_cnt_q, fault_cnt_d;
    logic                  sticky_q, sticky_d;

    assign inj_beat = in_valid_i && (inj_state_q == ARMED);
    assign dec1_in  = inj_beat ? (data_in_i ^ INJ_MASK) : data_in_i;

    (* keep = "true", dont_touch = "true" *)
    ecc_secded_dec #(
        .DATA_WIDTH   (DATA_WIDTH),
        .PARITY_WIDTH (PARITY_WIDTH)
    ) u_dec0 (
        .data_i     (data_in_i),
        .parity_i   (parity_in_i),
        .bypass_i   (bypass_i),
        .data_o     (data0),
        .mask_o     (mask0),
        .sbit_err_o (sbit0),
        .dbit_err_o (dbit0)
    );

    (* keep = "true", dont_touch = "true" *)
    ecc_secded_dec #(
        .DATA_WIDTH   (DATA_WIDTH),
        .PARITY_WIDTH (PARITY_WIDTH)
    ) u_dec1 (
        .data_i     (dec1_in),
        .parity_i   (parity_in_i),
        .bypass_i   (bypass_i),
        .data_o     (data1),
        .mask_o     (mask1),
        .sbit_err_o (sbit1),
        .dbit_err_o (dbit1)
    );

    // Copy 1 only votes through its flags and mask; its corrected data is never consumed.
    assign unused_data1 = ^data1;

    assign mismatch  = |({sbit0, dbit0, mask0} ^ {sbit1, dbit1, mask1});
    assign fault_now = in_valid_i && !inj_beat && det_en_i && mismatch;

    always_comb begin
        data_out_d  = data_out_q;
        sbit_d      = sbit_q;
        dbit_d      = dbit_q;
        fault_d     = fault_q;
        sbit_cnt_d  = sbit_cnt_q;
        dbit_cnt_d  = dbit_cnt_q;
        fault_cnt_d = fault_cnt_q;
        sticky_d    = sticky_q;
        if (in_valid_i) begin
            data_out_d = fault_now ? data_in_i : data0;
            sbit_d     = sbit0;
            dbit_d     = dbit0;
            fault_d    = fault_now;
            if (sbit0)     sbit_cnt_d  = sat_inc(sbit_cnt_q);
            if (dbit0)     dbit_cnt_d  = sat_inc(dbit_cnt_q);
            if (fault_now) fault_cnt_d = sat_inc(fault_cnt_q);
            if (fault_now) sticky_d    = 1'b1;
        end
        // Clear has priority over a coincident increment.
        if (cnt_clr_i) begin
            sbit_cnt_d  = '0;
            dbit_cnt_d  = '0;
            fault_cnt_d = '0;
            sticky_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            sbit_q      <= 1'b0;
            dbit_q      <= 1'b0;
            fault_q     <= 1'b0;
            sbit_cnt_q  <= '0;
            dbit_cnt_q  <= '0;
            fault_cnt_q <= '0;
            sticky_q    <= 1'b0;
        end else begin
            out_valid_q <= in_valid_i;
            data_out_q  <= data_out_d;
            sbit_q      <= sbit_d;
            dbit_q      <= dbit_d;
            fault_q     <= fault_d;
            sbit_cnt_q  <= sbit_cnt_d;
            dbit_cnt_q  <= dbit_cnt_d;
            fault_cnt_q <= fault_cnt_d;
            sticky_q    <= sticky_d;
        end
    end

    // Self-test sequencer: the injected beat's mismatch is reported one cycle after CHECK.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inj_state_q <= IDLE;
            inj_busy_q  <= 1'b0;
            inj_done_q  <= 1'b0;
            inj_pass_q  <= 1'b0;
            inj_mis_q   <= 1'b0;
        end else begin
            inj_done_q <= 1'b0;
            inj_pass_q <= 1'b0;
            unique case (inj_state_q)
                IDLE: begin
                    if (inj_req_i) begin
                        inj_state_q <= ARMED;
                        inj_busy_q  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (in_valid_i) begin
                        inj_state_q <= CHECK;
                        inj_mis_q   <= mismatch;
                    end
                end
                CHECK: begin
                    inj_state_q <= IDLE;
                    inj_busy_q  <= 1'b0;
                    inj_done_q  <= 1'b1;
                    inj_pass_q  <= inj_mis_q;
                end
                default: begin
                    inj_state_q <= IDLE;
                    inj_busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid_o    = out_valid_q;
    assign data_out_o     = data_out_q;
    assign sbit_err_o     = sbit_q;
    assign dbit_err_o     = dbit_q;
    assign ecc_fault_o    = fault_q;
    assign inj_busy_o     = inj_busy_q;
    assign inj_done_o     = inj_done_q;
    assign inj_pass_o     = inj_pass_q;
    assign sbit_cnt_o     = sbit_cnt_q;
    assign dbit_cnt_o     = dbit_cnt_q;
    assign fault_cnt_o    = fault_cnt_q;
    assign fault_sticky_o = sticky_q;
    assign fault_irq_o    = (fault_cnt_q >= CNT_WIDTH'(FAULT_THRESH));

endmodule

// File: tb/tb_ecc_lockstep_chk.sv
// Directed bench for ecc_lockstep_chk with a brute-force SECDED reference model.
module tb_ecc_lockstep_chk;

    localparam int DW = 70;
    localparam int PW = 8;
    localparam int CW = 4;

    typedef struct packed {
        logic          sb;
        logic          db;
        logic [DW-1:0] corr;
    } dres_t;

    logic          clk, rst;
    logic          in_valid, bypass, det_en, inj_req, cnt_clr;
    logic [DW-1:0] data_in;
    logic [PW-1:0] parity_in;
    logic          out_valid, sbit_err, dbit_err, ecc_fault;
    logic          inj_busy, inj_done, inj_pass, fault_sticky, fault_irq;
    logic [DW-1:0] data_out;
    logic [CW-1:0] sbit_cnt, dbit_cnt, fault_cnt;

    int errors = 0;
    int checks = 0;
    bit frc = 0;

    ecc_lockstep_chk #(
        .DATA_WIDTH   (DW),
        .PARITY_WIDTH (PW),
        .CNT_WIDTH    (CW),
        .FAULT_THRESH (1),
        .INJ_BIT      (0)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .in_valid_i     (in_valid),
        .data_in_i      (data_in),
        .parity_in_i    (parity_in),
        .bypass_i       (bypass),
        .det_en_i       (det_en),
        .inj_req_i      (inj_req),
        .cnt_clr_i      (cnt_clr),
        .out_valid_o    (out_valid),
        .data_out_o     (data_out),
        .sbit_err_o     (sbit_err),
        .dbit_err_o     (dbit_err),
        .ecc_fault_o    (ecc_fault),
        .inj_busy_o     (inj_busy),
        .inj_done_o     (inj_done),
        .inj_pass_o     (inj_pass),
        .sbit_cnt_o     (sbit_cnt),
        .dbit_cnt_o     (dbit_cnt),
        .fault_cnt_o    (fault_cnt),
        .fault_sticky_o (fault_sticky),
        .fault_irq_o    (fault_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    // Reference Hamming encoder: data bits occupy the non-power-of-two positions 3,5,6,7,9,...
    function automatic logic [PW-1:0] enc(input logic [DW-1:0] d);
        logic [PW-1:0] p;
        int pos;
        p = '0;
        pos = 0;
        for (int i = 0; i < DW; i++) begin
            pos++;
            while ((pos & (pos - 1)) == 0) pos++;
            if (d[i]) p[6:0] = p[6:0] ^ pos[6:0];
        end
        p[7] = (^d) ^ (^p[6:0]);
        return p;
    endfunction

    // Brute-force decode: search for a single flipped bit that restores a valid codeword.
    function automatic dres_t bdec(input logic [DW-1:0] d, input logic [PW-1:0] p, input logic byp);
        dres_t r;
        logic [DW-1:0] d2;
        r.sb = 1'b0;
        r.db = 1'b0;
        r.corr = d;
        if (byp || enc(d) == p) return r;
        for (int i = 0; i < DW; i++) begin
            d2 = d ^ (DW'(1) << i);
            if (enc(d2) == p) begin
                r.sb = 1'b1;
                r.corr = d2;
                return r;
            end
        end
        for (int j = 0; j < PW; j++) begin
            if (enc(d) == (p ^ (PW'(1) << j))) begin
                r.sb = 1'b1;
                return r;
            end
        end
        r.db = 1'b1;
        return r;
    endfunction

    // Model state and expected outputs
    logic          e_vld, e_sb, e_db, e_flt, e_busy, e_done, e_pass, e_sticky;
    logic [DW-1:0] e_dat;
    int            e_sc, e_dc, e_fc;
    bit            m_armed, m_chk, m_chk_pass, m_idle, m_inj, m_flt;
    dres_t         m_r0, m_r1;

    initial begin
        e_vld = 0; e_sb = 0; e_db = 0; e_flt = 0; e_busy = 0; e_done = 0; e_pass = 0;
        e_sticky = 0; e_dat = '0; e_sc = 0; e_dc = 0; e_fc = 0;
        m_armed = 0; m_chk = 0; m_chk_pass = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            e_vld = 0; e_dat = '0; e_sb = 0; e_db = 0; e_flt = 0;
            e_sc = 0; e_dc = 0; e_fc = 0; e_sticky = 0;
            e_done = 0; e_pass = 0;
            m_armed = 0; m_chk = 0; m_chk_pass = 0;
        end else begin
            m_idle = !m_armed && !m_chk;
            e_done = m_chk;
            e_pass = m_chk && m_chk_pass;
            m_chk = 0;
            e_vld = in_valid;
            if (in_valid) begin
                m_r0 = bdec(data_in, parity_in, bypass);
                m_inj = m_armed;
                if (m_inj) begin
                    m_r1 = bdec(data_in ^ DW'(1), parity_in, bypass);
                    m_chk_pass = (m_r0.sb != m_r1.sb) || (m_r0.db != m_r1.db) ||
                                 ((data_in ^ m_r0.corr) != ((data_in ^ DW'(1)) ^ m_r1.corr));
                    m_chk = 1;
                    m_armed = 0;
                end
                m_flt = !m_inj && det_en && frc;
                e_dat = m_flt ? data_in : m_r0.corr;
                e_sb = m_r0.sb;
                e_db = m_r0.db;
                e_flt = m_flt;
                if (m_r0.sb && e_sc < 15) e_sc++;
                if (m_r0.db && e_dc < 15) e_dc++;
                if (m_flt) begin
                    if (e_fc < 15) e_fc++;
                    e_sticky = 1;
                end
            end
            if (inj_req && m_idle) m_armed = 1;
            if (cnt_clr) begin
                e_sc = 0; e_dc = 0; e_fc = 0; e_sticky = 0;
            end
        end
        e_busy = m_armed || m_chk;
    end

    // Every-cycle comparison of all outputs against the model
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("out_valid", DW'(out_valid), DW'(e_vld));
            chk("data_out", data_out, e_dat);
            chk("sbit_err", DW'(sbit_err), DW'(e_sb));
            chk("dbit_err", DW'(dbit_err), DW'(e_db));
            chk("ecc_fault", DW'(ecc_fault), DW'(e_flt));
            chk("inj_busy", DW'(inj_busy), DW'(e_busy));
            chk("inj_done", DW'(inj_done), DW'(e_done));
            chk("inj_pass", DW'(inj_pass), DW'(e_pass));
            chk("sbit_cnt", DW'(sbit_cnt), DW'(e_sc));
            chk("dbit_cnt", DW'(dbit_cnt), DW'(e_dc));
            chk("fault_cnt", DW'(fault_cnt), DW'(e_fc));
            chk("fault_sticky", DW'(fault_sticky), DW'(e_sticky));
            chk("fault_irq", DW'(fault_irq), DW'(e_fc >= 1));
        end
    end

    task automatic beat(input logic [DW-1:0] d, input logic [PW-1:0] p, input logic byp);
        in_valid = 1'b1;
        data_in = d;
        parity_in = p;
        bypass = byp;
        @(negedge clk);
        in_valid = 1'b0;
        bypass = 1'b0;
    endtask

    logic [DW-1:0] d1, b3, b9, ones;

    initial begin
        rst = 1'b1; in_valid = 1'b0; bypass = 1'b0; det_en = 1'b1;
        inj_req = 1'b0; cnt_clr = 1'b0; data_in = '0; parity_in = '0;
        d1 = 70'h15_A5A5_A5A5_A5A5_A5A5;
        b3 = DW'(1) << 3;
        b9 = DW'(1) << 9;
        ones = '1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_out_valid", DW'(out_valid), '0);
        chk("reset_sbit_cnt", DW'(sbit_cnt), '0);

        // Pin the reference encoder with hand-computed check bits
        chk("enc_zero", DW'(enc('0)), '0);
        chk("enc_bit0", DW'(enc(DW'(1))), DW'(8'h83));
        chk("enc_bit3", DW'(enc(b3)), DW'(8'h07));

        // Clean beats
        beat(d1, enc(d1), 1'b0);
        chk("t1_data", data_out, 70'h15_A5A5_A5A5_A5A5_A5A5);
        chk("t1_sbit", DW'(sbit_err), '0);
        beat('0, enc('0), 1'b0);
        beat(ones, enc(ones), 1'b0);

        // Single and double errors in data and check bits
        beat(d1 ^ b3, enc(d1), 1'b0);
        chk("t2_corr", data_out, 70'h15_A5A5_A5A5_A5A5_A5A5);
        chk("t2_sbit_cnt", DW'(sbit_cnt), DW'(1));
        beat(d1 ^ b3 ^ b9, enc(d1), 1'b0);
        chk("t2_dbit", DW'(dbit_err), DW'(1));
        chk("t2_dbit_cnt", DW'(dbit_cnt), DW'(1));
        beat(d1, enc(d1) ^ 8'h04, 1'b0);
        beat(d1, enc(d1) ^ 8'h80, 1'b0);
        beat(ones ^ (DW'(1) << 69), enc(ones), 1'b0);
        beat(d1 ^ b9, enc(d1) ^ 8'h80, 1'b0);
        beat(d1 ^ b3, enc(d1), 1'b1);

        // Lockstep mismatch via forced copy-1 mask
        force dut.mask1 = 70'h1;
        frc = 1'b1;
        beat(d1 ^ b3, enc(d1), 1'b0);
        chk("t3_fault", DW'(ecc_fault), DW'(1));
        chk("t3_raw", data_out, 70'h15_A5A5_A5A5_A5A5_A5AD);
        chk("t3_sticky", DW'(fault_sticky), DW'(1));
        chk("t3_irq", DW'(fault_irq), DW'(1));
        det_en = 1'b0;
        beat(d1 ^ b3, enc(d1), 1'b0);
        chk("t3_noflt", DW'(ecc_fault), '0);
        chk("t3_fcnt", DW'(fault_cnt), DW'(1));
        release dut.mask1;
        frc = 1'b0;
        det_en = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("clr_irq", DW'(fault_irq), '0);

        // Self-test: arm, idle, injected beat; a request during CHECK is ignored
        inj_req = 1'b1;
        @(negedge clk);
        inj_req = 1'b0;
        repeat (3) @(negedge clk);
        beat(d1, enc(d1), 1'b0);
        chk("t4_busy", DW'(inj_busy), DW'(1));
        chk("t4_noflt", DW'(ecc_fault), '0);
        inj_req = 1'b1;
        @(negedge clk);
        inj_req = 1'b0;
        chk("t4_done", DW'(inj_done), DW'(1));
        chk("t4_pass", DW'(inj_pass), DW'(1));
        repeat (2) @(negedge clk);
        inj_req = 1'b1;
        @(negedge clk);
        inj_req = 1'b0;
        beat(d1 ^ b3, enc(d1), 1'b1);
        @(negedge clk);
        chk("t4b_done", DW'(inj_done), DW'(1));
        chk("t4b_pass", DW'(inj_pass), '0);
        chk("t4_fcnt", DW'(fault_cnt), '0);

        // Counter saturation, then clear coincident with an increment
        for (int k = 0; k < 20; k++) begin
            beat(d1 ^ (DW'(1) << (k * 3)), enc(d1), 1'b0);
        end
        chk("t5_sat", DW'(sbit_cnt), DW'(15));
        cnt_clr = 1'b1;
        beat(d1 ^ b9, enc(d1), 1'b0);
        cnt_clr = 1'b0;
        chk("t5_clr", DW'(sbit_cnt), '0);
        chk("t5_sbit", DW'(sbit_err), DW'(1));

        // Reset while armed discards the injection
        inj_req = 1'b1;
        @(negedge clk);
        inj_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_busy", DW'(inj_busy), '0);
        beat(d1, enc(d1), 1'b0);
        @(negedge clk);
        chk("t6_nodone", DW'(inj_done), '0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
        $fatal(1);
    end

endmodule
